// File: rtl/dsp_accum_pkg.sv
// Shared types and helpers for the frame accumulator datapath.
// Provides the FSM state encoding, the representation selector strings and
// saturation-limit helpers used by the saturating adder.
package dsp_accum_pkg;

  typedef enum logic {
    ACCUM = 1'b0,
    DUMP  = 1'b1
  } state_t;

  localparam string REP_SIGNED   = "SIGNED";
  localparam string REP_UNSIGNED = "UNSIGNED";

  // Helpers return a 64-bit pattern; callers truncate to their own width.
  localparam int unsigned SAT_FN_W = 64;

  // Largest representable value of a width-bit word.
  function automatic logic [SAT_FN_W-1:0] sat_max(input int unsigned width, input bit is_signed);
    logic [SAT_FN_W-1:0] one;
    one = SAT_FN_W'(1);
    if (is_signed) begin
      return (one << (width - 1)) - one;
    end
    if (width >= SAT_FN_W) begin
      return '1;
    end
    return (one << width) - one;
  endfunction

  // Smallest representable value; for signed words only the sign bit survives truncation.
  function automatic logic [SAT_FN_W-1:0] sat_min(input int unsigned width, input bit is_signed);
    if (is_signed) begin
      return SAT_FN_W'(1) << (width - 1);
    end
    return '0;
  endfunction

endpackage

// File: rtl/sat_adder.sv
// Combinational saturating adder.
// Ports:
//   a, b  in   WIDTH  operands, interpreted per REPRESENTATION
//   sum   out  WIDTH  a+b clamped to the representable range
//   sat   out  1      high when the clamp was applied
module sat_adder
  import dsp_accum_pkg::*;
#(
  parameter int unsigned WIDTH          = 24,
  parameter string       REPRESENTATION = "SIGNED"
) (
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic [WIDTH-1:0] sum,
  output logic             sat
);

  localparam bit               IS_SIGNED = (REPRESENTATION == REP_SIGNED);
  localparam logic [WIDTH-1:0] MAX_V     = WIDTH'(sat_max(WIDTH, IS_SIGNED));
  localparam logic [WIDTH-1:0] MIN_V     = WIDTH'(sat_min(WIDTH, IS_SIGNED));

  logic [WIDTH:0] raw;

  // One guard bit is enough to detect overflow of a two-operand add.
  always_comb begin
    if (IS_SIGNED) begin
      raw = {a[WIDTH-1], a} + {b[WIDTH-1], b};
    end else begin
      raw = {1'b0, a} + {1'b0, b};
    end
  end

  // Signed overflow shows as guard bit != result MSB; the guard bit gives the rail.
  always_comb begin
    sum = raw[WIDTH-1:0];
    sat = 1'b0;
    if (IS_SIGNED) begin
      if (raw[WIDTH] != raw[WIDTH-1]) begin
        sat = 1'b1;
        sum = raw[WIDTH] ? MIN_V : MAX_V;
      end
    end else if (raw[WIDTH]) begin
      sat = 1'b1;
      sum = MAX_V;
    end
  end

endmodule

// File: rtl/frame_accumulator.sv
// Frame accumulator: sums FRAME_LEN add/sub results into a saturating
// accumulator and hands one frame sum downstream per frame.
// Ports:
//   clock, aclr_n      rising-edge clock, async active-low reset
//   clken              clock enable; all state frozen when low
//   in_valid/in_ready  sample handshake (in_ready is combinational)
//   in_data, in_cout   add/sub result and carry (carry used only when UNSIGNED)
//   in_overflow        add/sub overflow, sticky per frame
//   frame_flush        close the current frame early
//   out_valid/ready    frame handshake
//   out_data           saturated frame sum
//   out_sat            accumulator clamped at least once in the frame
//   out_in_ovf         in_overflow seen on an accepted sample of the frame
//   out_count          samples in the frame
module frame_accumulator
  import dsp_accum_pkg::*;
#(
  parameter int unsigned IN_WIDTH       = 16,
  parameter int unsigned ACC_WIDTH      = 24,
  parameter int unsigned FRAME_LEN      = 8,
  parameter string       REPRESENTATION = "SIGNED"
) (
  input  logic                             clock,
  input  logic                             aclr_n,
  input  logic                             clken,
  input  logic                             in_valid,
  output logic                             in_ready,
  input  logic [IN_WIDTH-1:0]              in_data,
  input  logic                             in_cout,
  input  logic                             in_overflow,
  input  logic                             frame_flush,
  output logic                             out_valid,
  input  logic                             out_ready,
  output logic [ACC_WIDTH-1:0]             out_data,
  output logic                             out_sat,
  output logic                             out_in_ovf,
  output logic [$clog2(FRAME_LEN+1)-1:0]   out_count
);

  localparam int unsigned      CNT_W     = $clog2(FRAME_LEN + 1);
  localparam bit               IS_SIGNED = (REPRESENTATION == REP_SIGNED);
  localparam logic [CNT_W-1:0] LAST_IDX  = CNT_W'(FRAME_LEN - 1);

  // Parameter sanity checks at elaboration.
  if (ACC_WIDTH < IN_WIDTH + 1) begin : g_bad_acc_width
    $error("frame_accumulator: ACC_WIDTH must be >= IN_WIDTH+1");
  end
  if (FRAME_LEN < 1) begin : g_bad_frame_len
    $error("frame_accumulator: FRAME_LEN must be >= 1");
  end
  if ((REPRESENTATION != REP_SIGNED) && (REPRESENTATION != REP_UNSIGNED)) begin : g_bad_rep
    $error("frame_accumulator: REPRESENTATION must be SIGNED or UNSIGNED");
  end

  state_t                 state_q, state_d;
  logic [ACC_WIDTH-1:0]   acc_q, acc_d;
  logic [CNT_W-1:0]       count_q, count_d;
  logic                   sat_q, sat_d;
  logic                   ovf_q, ovf_d;
  logic                   out_valid_d;
  logic [ACC_WIDTH-1:0]   out_data_d;
  logic                   out_sat_d;
  logic                   out_in_ovf_d;
  logic [CNT_W-1:0]       out_count_d;

  logic [ACC_WIDTH-1:0]   ext;
  logic [ACC_WIDTH-1:0]   acc_sum;
  logic                   add_sat;
  logic                   accept;
  logic                   unused_cout;

  // The carry only matters for unsigned operation.
  assign unused_cout = in_cout;

  assign in_ready = clken & (state_q == ACCUM);
  assign accept   = in_valid & in_ready;

  // Widen the incoming sample to accumulator width.
  always_comb begin
    if (IS_SIGNED) begin
      ext = ACC_WIDTH'($signed(in_data));
    end else begin
      ext = ACC_WIDTH'({in_cout, in_data});
    end
  end

  sat_adder #(
    .WIDTH          (ACC_WIDTH),
    .REPRESENTATION (REPRESENTATION)
  ) u_sat_adder (
    .a   (acc_q),
    .b   (ext),
    .sum (acc_sum),
    .sat (add_sat)
  );

  // Next-state and output-register logic; nothing moves while clken is low.
  always_comb begin
    state_d      = state_q;
    acc_d        = acc_q;
    count_d      = count_q;
    sat_d        = sat_q;
    ovf_d        = ovf_q;
    out_valid_d  = out_valid;
    out_data_d   = out_data;
    out_sat_d    = out_sat;
    out_in_ovf_d = out_in_ovf;
    out_count_d  = out_count;
    if (clken) begin
      case (state_q)
        ACCUM: begin
          if (accept) begin
            acc_d   = acc_sum;
            count_d = count_q + CNT_W'(1);
            sat_d   = sat_q | add_sat;
            ovf_d   = ovf_q | in_overflow;
          end
          // A sample accepted alongside a flush belongs to the closing frame.
          if ((accept && (count_q == LAST_IDX)) || frame_flush) begin
            state_d      = DUMP;
            out_valid_d  = 1'b1;
            out_data_d   = acc_d;
            out_sat_d    = sat_d;
            out_in_ovf_d = ovf_d;
            out_count_d  = count_d;
          end
        end
        DUMP: begin
          if (out_ready) begin
            state_d     = ACCUM;
            out_valid_d = 1'b0;
            acc_d       = '0;
            count_d     = '0;
            sat_d       = 1'b0;
            ovf_d       = 1'b0;
          end
        end
      endcase
    end
  end

  // State and datapath registers.
  always_ff @(posedge clock or negedge aclr_n) begin
    if (!aclr_n) begin
      state_q    <= ACCUM;
      acc_q      <= '0;
      count_q    <= '0;
      sat_q      <= 1'b0;
      ovf_q      <= 1'b0;
      out_valid  <= 1'b0;
      out_data   <= '0;
      out_sat    <= 1'b0;
      out_in_ovf <= 1'b0;
      out_count  <= '0;
    end else begin
      state_q    <= state_d;
      acc_q      <= acc_d;
      count_q    <= count_d;
      sat_q      <= sat_d;
      ovf_q      <= ovf_d;
      out_valid  <= out_valid_d;
      out_data   <= out_data_d;
      out_sat    <= out_sat_d;
      out_in_ovf <= out_in_ovf_d;
      out_count  <= out_count_d;
    end
  end

endmodule

// File: tb/tb_frame_accumulator.sv
// Bench for frame_accumulator: two instances (signed and unsigned) share one
// stimulus stream; a frame-level reference model predicts each frame and a
// monitor compares frames as the DUTs present them.
module tb_frame_accumulator;

  typedef struct packed {
    logic [31:0] data;
    logic        sat;
    logic        ovf;
    logic [7:0]  cnt;
  } exp_t;

  logic        clock = 1'b0;
  logic        aclr_n = 1'b0;
  logic        clken = 1'b0;
  logic        in_valid = 1'b0;
  logic [15:0] in_data = '0;
  logic        in_cout = 1'b0;
  logic        in_overflow = 1'b0;
  logic        frame_flush = 1'b0;
  logic        out_ready = 1'b0;

  logic        rdy [2];
  logic        ov  [2];
  logic        os  [2];
  logic        oo  [2];
  logic [16:0] od0;
  logic [17:0] od1;
  logic [2:0]  oc0;
  logic [1:0]  oc1;
  logic [31:0] od  [2];
  logic [7:0]  oc  [2];

  assign od[0] = 32'(od0);
  assign od[1] = 32'(od1);
  assign oc[0] = 8'(oc0);
  assign oc[1] = 8'(oc1);

  int tests = 0;
  int fails = 0;

  // Reference model state (per DUT).
  longint macc [2];
  int     mcnt [2];
  bit     msat [2];
  bit     movf [2];
  bit     dumping [2];
  exp_t   exp_q0 [$];
  exp_t   exp_q1 [$];

  always #5 clock = ~clock;

  frame_accumulator #(
    .IN_WIDTH(16), .ACC_WIDTH(17), .FRAME_LEN(4), .REPRESENTATION("SIGNED")
  ) dut_s (
    .clock(clock), .aclr_n(aclr_n), .clken(clken), .in_valid(in_valid), .in_ready(rdy[0]),
    .in_data(in_data), .in_cout(in_cout), .in_overflow(in_overflow), .frame_flush(frame_flush),
    .out_valid(ov[0]), .out_ready(out_ready), .out_data(od0), .out_sat(os[0]),
    .out_in_ovf(oo[0]), .out_count(oc0)
  );

  frame_accumulator #(
    .IN_WIDTH(16), .ACC_WIDTH(18), .FRAME_LEN(2), .REPRESENTATION("UNSIGNED")
  ) dut_u (
    .clock(clock), .aclr_n(aclr_n), .clken(clken), .in_valid(in_valid), .in_ready(rdy[1]),
    .in_data(in_data), .in_cout(in_cout), .in_overflow(in_overflow), .frame_flush(frame_flush),
    .out_valid(ov[1]), .out_ready(out_ready), .out_data(od1), .out_sat(os[1]),
    .out_in_ovf(oo[1]), .out_count(oc1)
  );

  function automatic int frame_len(input int d);
    return (d == 0) ? 4 : 2;
  endfunction

  function automatic longint hi_lim(input int d);
    return (d == 0) ? 64'sd65535 : 64'sd262143;
  endfunction

  function automatic longint lo_lim(input int d);
    return (d == 0) ? -64'sd65536 : 64'sd0;
  endfunction

  function automatic longint sample_val(input int d, input logic [15:0] dat, input bit co);
    if (d == 0) return longint'($signed(dat));
    return longint'({co, dat});
  endfunction

  function automatic logic [31:0] to_bits(input int d, input longint v);
    longint m;
    m = (longint'(1) << ((d == 0) ? 17 : 18)) - 1;
    return 32'(v & m);
  endfunction

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] req);
    tests++;
    if (act !== req) begin
      fails++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, req);
    end
  endtask

  function automatic void push_exp(input int d, input exp_t e);
    if (d == 0) exp_q0.push_back(e);
    else exp_q1.push_back(e);
  endfunction

  function automatic int q_size(input int d);
    return (d == 0) ? exp_q0.size() : exp_q1.size();
  endfunction

  function automatic exp_t pop_exp(input int d);
    if (d == 0) return exp_q0.pop_front();
    return exp_q1.pop_front();
  endfunction

  // One clock cycle: check registered outputs, drive inputs, check in_ready, predict.
  task automatic cyc(input bit rst, input bit ce, input bit v, input logic [15:0] dat,
                     input bit co, input bit ofl, input bit fls, input bit ordy);
    exp_t   e;
    longint s;
    @(negedge clock);
    #1;
    for (int d = 0; d < 2; d++) chk($sformatf("out_valid[%0d]", d), 64'(ov[d]), 64'(dumping[d]));
    aclr_n      = ~rst;
    clken       = ce;
    in_valid    = v;
    in_data     = dat;
    in_cout     = co;
    in_overflow = ofl;
    frame_flush = fls;
    out_ready   = ordy;
    if (rst) begin
      for (int d = 0; d < 2; d++) begin
        macc[d] = 0; mcnt[d] = 0; msat[d] = 0; movf[d] = 0; dumping[d] = 0;
      end
    end
    #1;
    for (int d = 0; d < 2; d++) chk($sformatf("in_ready[%0d]", d), 64'(rdy[d]), 64'(ce && !dumping[d]));
    if (rst) begin
      for (int d = 0; d < 2; d++) begin
        chk($sformatf("rst_out_valid[%0d]", d), 64'(ov[d]), 64'd0);
        chk($sformatf("rst_out_data[%0d]", d), 64'(od[d]), 64'd0);
        chk($sformatf("rst_out_count[%0d]", d), 64'(oc[d]), 64'd0);
        chk($sformatf("rst_flags[%0d]", d), 64'({os[d], oo[d]}), 64'd0);
      end
    end else if (ce) begin
      for (int d = 0; d < 2; d++) begin
        if (dumping[d]) begin
          if (ordy) dumping[d] = 0;
        end else begin
          if (v) begin
            s = macc[d] + sample_val(d, dat, co);
            if (s > hi_lim(d)) begin s = hi_lim(d); msat[d] = 1; end
            else if (s < lo_lim(d)) begin s = lo_lim(d); msat[d] = 1; end
            macc[d] = s;
            mcnt[d]++;
            movf[d] |= ofl;
          end
          if ((v && mcnt[d] == frame_len(d)) || fls) begin
            e.data = to_bits(d, macc[d]);
            e.sat  = msat[d];
            e.ovf  = movf[d];
            e.cnt  = 8'(mcnt[d]);
            push_exp(d, e);
            dumping[d] = 1;
            macc[d] = 0; mcnt[d] = 0; msat[d] = 0; movf[d] = 0;
          end
        end
      end
    end
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) cyc(0, 1, 0, 16'h0, 0, 0, 0, 1);
  endtask

  // Monitor: compare each newly presented frame, then require it to stay stable.
  exp_t held [2];
  bit   prev [2];
  initial begin : monitor
    prev[0] = 0;
    prev[1] = 0;
    forever begin
      @(negedge clock);
      for (int d = 0; d < 2; d++) begin
        if (ov[d] === 1'b1 && !prev[d]) begin
          if (q_size(d) == 0) begin
            tests++;
            fails++;
            $display("FAIL frame_unexpected[%0d]: out_valid=1 with no frame expected, out_data=0x%0h", d, od[d]);
            held[d] = {od[d], os[d], oo[d], oc[d]};
          end else begin
            held[d] = pop_exp(d);
          end
        end
        if (ov[d] === 1'b1) begin
          chk($sformatf("out_data[%0d]", d), 64'(od[d]), 64'(held[d].data));
          chk($sformatf("out_sat[%0d]", d), 64'(os[d]), 64'(held[d].sat));
          chk($sformatf("out_in_ovf[%0d]", d), 64'(oo[d]), 64'(held[d].ovf));
          chk($sformatf("out_count[%0d]", d), 64'(oc[d]), 64'(held[d].cnt));
        end
        prev[d] = (ov[d] === 1'b1);
      end
    end
  end

  initial begin : stimulus
    int sel;
    logic [15:0] dat;
    for (int d = 0; d < 2; d++) begin
      macc[d] = 0; mcnt[d] = 0; msat[d] = 0; movf[d] = 0; dumping[d] = 0;
    end
    // Reset
    for (int i = 0; i < 3; i++) cyc(1, 1, 0, 16'h0, 0, 0, 0, 1);
    idle(2);
    // Back-to-back 1,2,3,4
    for (int i = 1; i <= 4; i++) cyc(0, 1, 1, 16'(i), 0, 0, 0, 1);
    idle(3);
    // Positive then negative saturation
    for (int i = 0; i < 4; i++) cyc(0, 1, 1, 16'h7FFF, 0, 0, 0, 1);
    idle(3);
    for (int i = 0; i < 4; i++) cyc(0, 1, 1, 16'h8000, 0, 0, 0, 1);
    idle(3);
    // Carry-extended unsigned samples
    for (int i = 0; i < 2; i++) cyc(0, 1, 1, 16'hFFFF, 1, 0, 0, 1);
    idle(3);
    // Flush coinciding with a sample, then flush while idle
    for (int i = 0; i < 3; i++) cyc(0, 1, 1, 16'd5, 0, 0, 0, 1);
    cyc(0, 1, 1, 16'd5, 0, 0, 1, 1);
    idle(3);
    cyc(0, 1, 0, 16'd0, 0, 0, 1, 1);
    idle(3);
    // Back-pressure in DUMP, overflow on the 2nd sample, then a clean frame
    for (int i = 0; i < 4; i++) cyc(0, 1, 1, 16'(i + 7), 0, (i == 1), 0, 0);
    for (int i = 0; i < 10; i++) cyc(0, 1, 1, 16'd3, 0, 0, 1, 0);
    idle(2);
    for (int i = 0; i < 4; i++) cyc(0, 1, 1, 16'd2, 0, 0, 0, 1);
    idle(3);
    // Reset mid-frame, then a frame with clken toggling
    cyc(0, 1, 1, 16'd9, 0, 0, 0, 1);
    cyc(0, 1, 1, 16'd9, 0, 0, 0, 1);
    cyc(1, 1, 0, 16'd0, 0, 0, 0, 1);
    for (int i = 0; i < 4; i++) begin
      cyc(0, 1, 1, 16'(i + 1), 0, 0, 0, 1);
      cyc(0, 0, 1, 16'd100, 0, 1, 1, 1);
    end
    idle(4);
    // Randomized traffic
    for (int i = 0; i < 3000; i++) begin
      sel = int'($urandom_range(0, 3));
      case (sel)
        0: dat = 16'h7FFF;
        1: dat = 16'h8000;
        2: dat = 16'($urandom_range(0, 15));
        default: dat = 16'($urandom);
      endcase
      cyc(($urandom_range(0, 199) == 0), ($urandom_range(0, 9) < 8), ($urandom_range(0, 9) < 7),
          dat, 1'($urandom), ($urandom_range(0, 9) == 0), ($urandom_range(0, 19) == 0),
          ($urandom_range(0, 9) < 6));
    end
    idle(10);
    chk("pending_frames", 64'(exp_q0.size() + exp_q1.size()), 64'd0);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
